dm_arbiter: RTL and testbench
=============================

# dm_arbiter

Two-master arbiter that shares the single-port data memory between the pipeline MEM stage (master 0) and a secondary master (master 1: debug/loader/DMA port). It sits directly in front of `dm`. It grants one master per cycle with a same-cycle req/gnt handshake and drives `dm`'s write-enable, address, write data and PC. Contention is resolved round-robin with bounded bursts, so neither master can starve the other.

## Interface
- `MAX_BURST`, 4: maximum consecutive beats one master keeps the grant while the other master is requesting; legal range 1..15.
- `clk`  input  1  system clock; all state updates on the rising edge.
- `reset`  input  1  synchronous, active-high reset.
- `m0Req`, `m1Req`  input  1  master requests an access this cycle.
- `m0We`, `m1We`  input  1  1 = write, 0 = read.
- `m0Addr`, `m1Addr`  input  32  byte address, passed to `dm` unchanged.
- `m0WriteData`, `m1WriteData`  input  32  store data.
- `m0Pc`, `m1Pc`  input  32  PC tag forwarded to `dm` for write logging.
- `m0Gnt`, `m1Gnt`  output  1  access accepted this cycle; combinational from the current request inputs and arbiter state.
- `m0ReadData`, `m1ReadData`  output  32  both equal `dmReadData`; valid for a master only in a cycle where its `Gnt` = 1.
- `dmMemWrite`  output  1  to `dm` memWrite.
- `dmMemAddr`, `dmWriteData`, `dmPc`  output  32  to `dm`.
- `dmReadData`  input  32  from `dm` readData (combinational read).

## Operation
- State registers:
  - `owner` ∈ {NONE, M0, M1}.
  - `lastServed` ∈ {M0, M1}.
  - `burstCnt`, 4 bits.
- `keep` = `owner` ≠ NONE AND `req[owner]` AND (`burstCnt` < MAX_BURST OR NOT `req[other]`).
- Select `sel`:
  - if `keep`: `sel` = `owner`;
  - else if both masters request: `sel` = the master ≠ `lastServed`;
  - else if exactly one requests: `sel` = that master;
  - else: `sel` = NONE.
- `mXGnt` = (`sel` == X) AND NOT `reset`. At most one grant is high in any cycle.
- Datapath mux:
  - `dmMemAddr`, `dmWriteData` and `dmPc` come from the selected master.
  - When `sel` = NONE they come from master 0, and `dmMemWrite` = 0.
  - `dmMemWrite` = `we[sel]` AND any grant.
- Rising-edge update when not in reset:
  - `owner` <= `sel`.
  - `lastServed` <= `sel` if `sel` ≠ NONE; otherwise unchanged.
  - `burstCnt`:
    - `keep`: `burstCnt` + 1, saturating at MAX_BURST;
    - new owner selected: 1;
    - NONE: 0.
- Ownership is released as soon as the owner drops `req`. The other master, if requesting, is granted in that same cycle.
- Arbitration does not depend on `we`. A read and a write are arbitrated identically.

## Timing
- Reset (synchronous):
  - `owner` = NONE, `lastServed` = M1 (so M0 wins the first tie), `burstCnt` = 0.
  - While `reset` = 1, both grants = 0 and `dmMemWrite` = 0. The dm is cleared by the same reset.
- A reset asserted mid-burst aborts the burst. The first cycle after reset arbitrates from the reset state.
- Latency:
  - Grant is 0 cycles: same cycle as `req`.
  - Read data is valid in the grant cycle (dm read is combinational).
  - A write commits at the rising edge that ends the grant cycle.
- Handshake: a transfer occurs on each cycle with `req` AND `gnt`. A master denied a grant must hold `req`, `we`, `addr` and `wdata` stable until granted.
- Burst bound: while both masters request continuously, each master receives exactly MAX_BURST consecutive grants before the hand-over.
- A lone requester is granted every cycle indefinitely; `burstCnt` saturates and does not wrap.
- Simultaneous new requests with `owner` = NONE: the master ≠ `lastServed` wins.

## Test plan
- Reset then single master: assert reset 2 cycles, release; M0 writes 0x1234ABCD to 0x00000010 with `m0Pc` = 0x3000 -> `m0Gnt` = 1 same cycle, `dmMemWrite` = 1; the next-cycle read of 0x10 returns 0x1234ABCD. Grants are 0 throughout the reset cycles.
- Tie after reset: both masters read in the first cycle -> `m0Gnt` = 1, `m1Gnt` = 0. M0 then drops `req` -> `m1Gnt` = 1 in the same cycle.
- Continuous contention, MAX_BURST = 4: both hold `req` for 12 cycles -> grant sequence M0×4, M1×4, M0×4. Never both grants high; `dmMemWrite` follows the granted `we` only.
- Lone long burst: M1 requests 20 cycles with M0 idle -> `m1Gnt` = 1 for all 20. M0 then requests at cycle 21 while M1 continues -> M0 is granted at cycle 21, since `burstCnt` was saturated at 4.
- Reset mid-burst: M0 owns with `burstCnt` = 2, reset asserted 1 cycle while both request -> grants 0 and no write that cycle. The next cycle M0 wins (`lastServed` reset to M1).
- Idle and held request: no requests -> `dmMemWrite` = 0 and `owner` NONE. A denied M1 write (addr 0x20, data 0xDEADBEEF) held until granted -> exactly one write to 0x20, logged with `m1Pc`.

Source files
------------

// File: rtl/dm_arbiter.sv
// -----------------------------------------------------------------------------
// dm_arbiter
//
// Shares the single-port data memory between the pipeline MEM stage (master 0)
// and a secondary debug/loader/DMA master (master 1). One master is granted per
// cycle with a same-cycle req/gnt handshake. Contention is resolved round-robin,
// and a master may hold the grant for at most MAX_BURST beats while the other
// master waits, so neither master can starve the other.
//
// Parameters
//   MAX_BURST     max consecutive beats for one master under contention (1..15)
//
// Ports
//   clk           system clock, all state updates on the rising edge
//   reset         synchronous, active-high reset
//   m0Req/m1Req   master requests an access this cycle
//   m0We/m1We     1 = write, 0 = read
//   m0Addr/m1Addr byte address, forwarded to dm unchanged
//   m0WriteData/m1WriteData  store data
//   m0Pc/m1Pc     PC tag forwarded to dm for write logging
//   m0Gnt/m1Gnt   access accepted this cycle (combinational)
//   m0ReadData/m1ReadData    copies of dmReadData, valid only while granted
//   dmMemWrite    write enable to dm
//   dmMemAddr/dmWriteData/dmPc  address, store data and PC tag to dm
//   dmReadData    combinational read data from dm
// -----------------------------------------------------------------------------
module dm_arbiter #(
  parameter int unsigned MAX_BURST = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m0Req,
  input  logic        m1Req,
  input  logic        m0We,
  input  logic        m1We,
  input  logic [31:0] m0Addr,
  input  logic [31:0] m1Addr,
  input  logic [31:0] m0WriteData,
  input  logic [31:0] m1WriteData,
  input  logic [31:0] m0Pc,
  input  logic [31:0] m1Pc,
  output logic        m0Gnt,
  output logic        m1Gnt,
  output logic [31:0] m0ReadData,
  output logic [31:0] m1ReadData,
  output logic        dmMemWrite,
  output logic [31:0] dmMemAddr,
  output logic [31:0] dmWriteData,
  output logic [31:0] dmPc,
  input  logic [31:0] dmReadData
);

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_M0   = 2'd1,
    OWN_M1   = 2'd2
  } owner_e;

  localparam logic [3:0] MaxBurst = 4'(MAX_BURST);

  owner_e     owner_q, owner_d;
  owner_e     sel;
  // 0 = master 0 was served last, 1 = master 1 was served last
  logic       lastServed_q, lastServed_d;
  logic [3:0] burstCnt_q, burstCnt_d;

  logic       ownerReq;
  logic       otherReq;
  logic       keep;

  // Arbitration: the current owner keeps the grant while it still requests,
  // unless its burst is exhausted and the other master is waiting. Otherwise
  // a tie goes to the master that was not served last.
  always_comb begin
    ownerReq = 1'b0;
    otherReq = 1'b0;
    case (owner_q)
      OWN_M0: begin
        ownerReq = m0Req;
        otherReq = m1Req;
      end
      OWN_M1: begin
        ownerReq = m1Req;
        otherReq = m0Req;
      end
      default: begin
        ownerReq = 1'b0;
        otherReq = 1'b0;
      end
    endcase

    keep = (owner_q != OWN_NONE) && ownerReq &&
           ((burstCnt_q < MaxBurst) || !otherReq);

    if (keep) begin
      sel = owner_q;
    end else if (m0Req && m1Req) begin
      sel = lastServed_q ? OWN_M0 : OWN_M1;
    end else if (m0Req) begin
      sel = OWN_M0;
    end else if (m1Req) begin
      sel = OWN_M1;
    end else begin
      sel = OWN_NONE;
    end
  end

  // Grants are suppressed during reset so nothing reaches dm in that cycle;
  // the datapath defaults to master 0 when nobody is selected.
  always_comb begin
    m0Gnt       = (sel == OWN_M0) && !reset;
    m1Gnt       = (sel == OWN_M1) && !reset;
    dmMemWrite  = (m0Gnt && m0We) || (m1Gnt && m1We);
    dmMemAddr   = m0Addr;
    dmWriteData = m0WriteData;
    dmPc        = m0Pc;
    if (sel == OWN_M1) begin
      dmMemAddr   = m1Addr;
      dmWriteData = m1WriteData;
      dmPc        = m1Pc;
    end
    m0ReadData = dmReadData;
    m1ReadData = dmReadData;
  end

  // Next state: the burst counter saturates at MAX_BURST so a lone requester
  // never wraps around and is still seen as exhausted once the other shows up.
  always_comb begin
    owner_d      = sel;
    lastServed_d = lastServed_q;
    burstCnt_d   = 4'd0;
    case (sel)
      OWN_M0:  lastServed_d = 1'b0;
      OWN_M1:  lastServed_d = 1'b1;
      default: lastServed_d = lastServed_q;
    endcase
    if (keep) begin
      burstCnt_d = (burstCnt_q >= MaxBurst) ? MaxBurst : burstCnt_q + 4'd1;
    end else if (sel != OWN_NONE) begin
      burstCnt_d = 4'd1;
    end else begin
      burstCnt_d = 4'd0;
    end
  end

  // State registers; reset leaves master 1 as last served so master 0 wins
  // the first tie.
  always_ff @(posedge clk) begin
    if (reset) begin
      owner_q      <= OWN_NONE;
      lastServed_q <= 1'b1;
      burstCnt_q   <= 4'd0;
    end else begin
      owner_q      <= owner_d;
      lastServed_q <= lastServed_d;
      burstCnt_q   <= burstCnt_d;
    end
  end

endmodule

// File: tb/tb_dm_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dm_arbiter
//
// Self-checking bench for dm_arbiter. A small word memory stands in for dm.
// The reference model tracks who holds the memory, how many beats in a row it
// has had and who was served last, as plain integers, plus an expected memory
// image. Directed scenarios are followed by a randomized run.
// -----------------------------------------------------------------------------
module tb_dm_arbiter;

  localparam int MAX_BURST = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        req   [2];
  logic        we    [2];
  logic [31:0] addr  [2];
  logic [31:0] wdata [2];
  logic [31:0] pc    [2];

  logic        m0Gnt, m1Gnt;
  logic [31:0] m0ReadData, m1ReadData;
  logic        dmMemWrite;
  logic [31:0] dmMemAddr, dmWriteData, dmPc, dmReadData;

  int checkCount = 0;
  int passCount  = 0;

  // reference model state
  int          mHolder;
  int          mRun;
  int          mLast;
  logic [31:0] refMem [256];

  // stand-in data memory
  logic [31:0] memArr [256];
  int          wr20 = 0;
  logic [31:0] pc20 = '0;

  always #5 clk = ~clk;

  dm_arbiter #(.MAX_BURST(MAX_BURST)) dut (
    .clk         (clk),
    .reset       (rst),
    .m0Req       (req[0]),
    .m1Req       (req[1]),
    .m0We        (we[0]),
    .m1We        (we[1]),
    .m0Addr      (addr[0]),
    .m1Addr      (addr[1]),
    .m0WriteData (wdata[0]),
    .m1WriteData (wdata[1]),
    .m0Pc        (pc[0]),
    .m1Pc        (pc[1]),
    .m0Gnt       (m0Gnt),
    .m1Gnt       (m1Gnt),
    .m0ReadData  (m0ReadData),
    .m1ReadData  (m1ReadData),
    .dmMemWrite  (dmMemWrite),
    .dmMemAddr   (dmMemAddr),
    .dmWriteData (dmWriteData),
    .dmPc        (dmPc),
    .dmReadData  (dmReadData)
  );

  assign dmReadData = memArr[dmMemAddr[9:2]];

  always @(posedge clk) begin
    if (rst) begin
      foreach (memArr[i]) memArr[i] <= '0;
    end else if (dmMemWrite) begin
      memArr[dmMemAddr[9:2]] <= dmWriteData;
      if (dmMemAddr == 32'h20) begin
        wr20 <= wr20 + 1;
        pc20 <= dmPc;
      end
    end
  end

  // Winner this cycle from the arbitration rules: -1 means nobody.
  function automatic int modelSel();
    if (rst) return -1;
    if (mHolder >= 0 && req[mHolder] && (mRun < MAX_BURST || !req[1 - mHolder]))
      return mHolder;
    if (req[0] && req[1]) return 1 - mLast;
    if (req[0]) return 0;
    if (req[1]) return 1;
    return -1;
  endfunction

  task automatic advance();
    int s;
    @(posedge clk);
    s = modelSel();
    if (rst) begin
      mHolder = -1;
      mLast   = 1;
      mRun    = 0;
      foreach (refMem[i]) refMem[i] = '0;
    end else begin
      if (s >= 0 && we[s]) refMem[addr[s][9:2]] = wdata[s];
      if (s >= 0 && s == mHolder) mRun = mRun + 1;
      else mRun = (s >= 0) ? 1 : 0;
      mHolder = s;
      if (s >= 0) mLast = s;
    end
    #1;
  endtask

  task automatic idleInputs();
    for (int m = 0; m < 2; m++) begin
      req[m]   = 1'b0;
      we[m]    = 1'b0;
      addr[m]  = '0;
      wdata[m] = '0;
      pc[m]    = '0;
    end
  endtask

  task automatic pulseReset();
    rst = 1'b1;
    idleInputs();
    advance();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req[0] = 1'b1; req[1] = 1'b1; we[0] = 1'b1; we[1] = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      checkCount++;
      if (m0Gnt !== 1'b0) $display("[TB] FAIL reset_m0Gnt: got %b want 0", m0Gnt);
      else passCount++;
      checkCount++;
      if (m1Gnt !== 1'b0) $display("[TB] FAIL reset_m1Gnt: got %b want 0", m1Gnt);
      else passCount++;
      checkCount++;
      if (dmMemWrite !== 1'b0) $display("[TB] FAIL reset_write: got %b want 0", dmMemWrite);
      else passCount++;
      advance();
    end
    rst = 1'b0;
    idleInputs();
  endtask

  task automatic test_single_write();
    req[0] = 1'b1; we[0] = 1'b1; addr[0] = 32'h10; wdata[0] = 32'h1234ABCD; pc[0] = 32'h3000;
    @(negedge clk);
    checkCount++;
    if (m0Gnt !== 1'b1) $display("[TB] FAIL single_gnt: got %b want 1", m0Gnt);
    else passCount++;
    checkCount++;
    if (dmMemWrite !== 1'b1) $display("[TB] FAIL single_write: got %b want 1", dmMemWrite);
    else passCount++;
    checkCount++;
    if ({dmMemAddr, dmWriteData, dmPc} !== {32'h10, 32'h1234ABCD, 32'h3000})
      $display("[TB] FAIL single_bus: got %h/%h/%h want 00000010/1234abcd/00003000",
               dmMemAddr, dmWriteData, dmPc);
    else passCount++;
    advance();
    we[0] = 1'b0;
    @(negedge clk);
    checkCount++;
    if (m0ReadData !== 32'h1234ABCD) $display("[TB] FAIL single_read: got %h want 1234abcd", m0ReadData);
    else passCount++;
    advance();
    idleInputs();
  endtask

  task automatic test_tie();
    pulseReset();
    req[0] = 1'b1; req[1] = 1'b1; addr[1] = 32'h10;
    @(negedge clk);
    checkCount++;
    if ({m0Gnt, m1Gnt} !== 2'b10) $display("[TB] FAIL tie_first: got m0/m1 %b%b want 10", m0Gnt, m1Gnt);
    else passCount++;
    advance();
    req[0] = 1'b0;
    @(negedge clk);
    checkCount++;
    if ({m0Gnt, m1Gnt} !== 2'b01) $display("[TB] FAIL tie_handover: got m0/m1 %b%b want 01", m0Gnt, m1Gnt);
    else passCount++;
    advance();
    idleInputs();
  endtask

  task automatic test_contention();
    int w;
    pulseReset();
    req[0] = 1'b1; req[1] = 1'b1; we[0] = 1'b1; we[1] = 1'b0;
    addr[0] = 32'h100; addr[1] = 32'h200; wdata[0] = 32'h55AA55AA;
    for (int i = 0; i < 12; i++) begin
      w = (i / MAX_BURST) % 2;
      @(negedge clk);
      checkCount++;
      if (m0Gnt !== (w == 0) || m1Gnt !== (w == 1))
        $display("[TB] FAIL contention_beat%0d: got m0/m1 %b%b want master %0d", i, m0Gnt, m1Gnt, w);
      else passCount++;
      checkCount++;
      if (dmMemWrite !== (w == 0))
        $display("[TB] FAIL contention_we%0d: got %b want %b", i, dmMemWrite, (w == 0));
      else passCount++;
      advance();
    end
    idleInputs();
  endtask

  task automatic test_lone_burst();
    pulseReset();
    req[1] = 1'b1; addr[1] = 32'h44;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      checkCount++;
      if ({m0Gnt, m1Gnt} !== 2'b01) $display("[TB] FAIL lone_beat%0d: got m0/m1 %b%b want 01", i, m0Gnt, m1Gnt);
      else passCount++;
      advance();
    end
    req[0] = 1'b1;
    @(negedge clk);
    checkCount++;
    if ({m0Gnt, m1Gnt} !== 2'b10) $display("[TB] FAIL lone_takeover: got m0/m1 %b%b want 10", m0Gnt, m1Gnt);
    else passCount++;
    advance();
    idleInputs();
  endtask

  task automatic test_reset_mid_burst();
    pulseReset();
    req[0] = 1'b1; addr[0] = 32'h40;
    advance();
    advance();
    rst = 1'b1; req[1] = 1'b1; we[0] = 1'b1; wdata[0] = 32'hCAFEF00D;
    @(negedge clk);
    checkCount++;
    if ({m0Gnt, m1Gnt, dmMemWrite} !== 3'b000)
      $display("[TB] FAIL midreset_quiet: got gnt %b%b we %b want 000", m0Gnt, m1Gnt, dmMemWrite);
    else passCount++;
    advance();
    rst = 1'b0; we[0] = 1'b0;
    @(negedge clk);
    checkCount++;
    if ({m0Gnt, m1Gnt} !== 2'b10) $display("[TB] FAIL midreset_winner: got m0/m1 %b%b want 10", m0Gnt, m1Gnt);
    else passCount++;
    checkCount++;
    if (m0ReadData !== 32'h0) $display("[TB] FAIL midreset_nowrite: got %h want 00000000", m0ReadData);
    else passCount++;
    advance();
    idleInputs();
  endtask

  task automatic test_idle_held();
    int base;
    pulseReset();
    base = wr20;
    @(negedge clk);
    checkCount++;
    if ({m0Gnt, m1Gnt, dmMemWrite} !== 3'b000)
      $display("[TB] FAIL idle_quiet: got gnt %b%b we %b want 000", m0Gnt, m1Gnt, dmMemWrite);
    else passCount++;
    advance();
    req[0] = 1'b1; addr[0] = 32'h0;
    req[1] = 1'b1; we[1] = 1'b1; addr[1] = 32'h20; wdata[1] = 32'hDEADBEEF; pc[1] = 32'h4444;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      checkCount++;
      if ({m0Gnt, m1Gnt, dmMemWrite} !== 3'b100)
        $display("[TB] FAIL held_denied%0d: got gnt %b%b we %b want 100", c, m0Gnt, m1Gnt, dmMemWrite);
      else passCount++;
      advance();
    end
    req[0] = 1'b0;
    @(negedge clk);
    checkCount++;
    if ({m0Gnt, m1Gnt, dmMemWrite} !== 3'b011)
      $display("[TB] FAIL held_granted: got gnt %b%b we %b want 011", m0Gnt, m1Gnt, dmMemWrite);
    else passCount++;
    advance();
    req[1] = 1'b0; we[1] = 1'b0; req[0] = 1'b1; addr[0] = 32'h20;
    @(negedge clk);
    checkCount++;
    if (wr20 - base !== 1 || pc20 !== 32'h4444)
      $display("[TB] FAIL held_once: got %0d writes pc %h want 1 writes pc 00004444", wr20 - base, pc20);
    else passCount++;
    checkCount++;
    if (m0ReadData !== 32'hDEADBEEF) $display("[TB] FAIL held_data: got %h want deadbeef", m0ReadData);
    else passCount++;
    advance();
    idleInputs();
  endtask

  task automatic test_random();
    int g;
    int prevG;
    logic prevRst;
    logic [31:0] expRd;
    logic expWe;
    pulseReset();
    prevG = -1;
    prevRst = 1'b1;
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 39) == 0);
      for (int m = 0; m < 2; m++) begin
        // a denied master holds its request until granted
        if (!(req[m] && prevG != m && !prevRst)) begin
          req[m]   = ($urandom_range(0, 3) != 0);
          we[m]    = $urandom_range(0, 1) == 1;
          addr[m]  = {22'd0, 8'($urandom_range(0, 255)), 2'b00};
          wdata[m] = $urandom;
          pc[m]    = $urandom;
        end
      end
      g = modelSel();
      expWe = (g >= 0) ? we[g] : 1'b0;
      expRd = (g >= 0) ? refMem[addr[g][9:2]] : refMem[addr[0][9:2]];
      @(negedge clk);
      checkCount++;
      if (m0Gnt !== (g == 0) || m1Gnt !== (g == 1) || dmMemWrite !== expWe)
        $display("[TB] FAIL rand_gnt%0d: got gnt %b%b we %b want sel %0d we %b",
                 i, m0Gnt, m1Gnt, dmMemWrite, g, expWe);
      else passCount++;
      if (!rst) begin
        checkCount++;
        if (g == 1 ? {dmMemAddr, dmWriteData, dmPc} !== {addr[1], wdata[1], pc[1]}
                   : {dmMemAddr, dmWriteData, dmPc} !== {addr[0], wdata[0], pc[0]})
          $display("[TB] FAIL rand_bus%0d: got %h/%h/%h for sel %0d", i, dmMemAddr, dmWriteData, dmPc, g);
        else passCount++;
        if (g >= 0) begin
          checkCount++;
          if ((g == 0 ? m0ReadData : m1ReadData) !== expRd)
            $display("[TB] FAIL rand_read%0d: got %h want %h", i, (g == 0 ? m0ReadData : m1ReadData), expRd);
          else passCount++;
        end
      end
      prevG = g;
      prevRst = rst;
      advance();
    end
    rst = 1'b0;
    idleInputs();
  endtask

  initial begin
    mHolder = -1;
    mRun    = 0;
    mLast   = 1;
    foreach (refMem[i]) refMem[i] = '0;
    rst = 1'b1;
    idleInputs();
    advance();
    test_reset();
    test_single_write();
    test_tie();
    test_contention();
    test_lone_burst();
    test_reset_mid_burst();
    test_idle_held();
    test_random();
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
